// File: rtl/dispatch_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_decode_pkg
// Description : Shared types and constants for the Tomasulo decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dispatch_decode_pkg;

  localparam int GPR_IDX_SIZE   = 5;
  localparam int GPR_SIZE       = 64;
  localparam int IMMEDIATE_SIZE = 64;
  localparam int ROB_IDX_SIZE   = 5;

  // Index 31 reads as zero and discards writes.
  localparam logic [GPR_IDX_SIZE-1:0] GPR_XZR = '1;

  typedef logic [3:0] cond_t;
  typedef logic [3:0] nzcv_t;

  localparam cond_t COND_AL = 4'b1110;

  // Exact encoding of the architectural NOP hint.
  localparam logic [31:0] NOP_INSN = 32'hD503_201F;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_ADDS  = 5'd2,
    OP_SUB   = 5'd3,
    OP_SUBS  = 5'd4,
    OP_AND   = 5'd5,
    OP_ANDS  = 5'd6,
    OP_ORR   = 5'd7,
    OP_EOR   = 5'd8,
    OP_ORN   = 5'd9,
    OP_MOVZ  = 5'd10,
    OP_LDUR  = 5'd11,
    OP_STUR  = 5'd12,
    OP_BCOND = 5'd13,
    OP_CSEL  = 5'd14,
    OP_CSINC = 5'd15,
    OP_CSINV = 5'd16,
    OP_CSNEG = 5'd17,
    OP_HLT   = 5'd18,
    OP_ERROR = 5'd19
  } opcode_t;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_ALU  = 2'd1,
    FU_LS   = 2'd2
  } fu_t;

  typedef enum logic [3:0] {
    FU_OP_PASS  = 4'd0,
    FU_OP_PLUS  = 4'd1,
    FU_OP_MINUS = 4'd2,
    FU_OP_AND   = 4'd3,
    FU_OP_ORR   = 4'd4,
    FU_OP_EOR   = 4'd5,
    FU_OP_ORN   = 4'd6,
    FU_OP_MOV   = 4'd7,
    FU_OP_BCOND = 4'd8,
    FU_OP_CSEL  = 4'd9,
    FU_OP_CSINC = 4'd10,
    FU_OP_CSINV = 4'd11,
    FU_OP_CSNEG = 4'd12
  } fu_op_t;

  typedef struct packed {
    opcode_t                   opcode;
    logic [GPR_IDX_SIZE-1:0]   src1;
    logic [GPR_IDX_SIZE-1:0]   src2;
    logic [GPR_IDX_SIZE-1:0]   dst;
    logic                      use_imm;
    logic [IMMEDIATE_SIZE-1:0] imm;
    fu_t                       fu_id;
    fu_op_t                    fu_op;
    logic                      set_nzcv;
    logic                      uses_nzcv;
    cond_t                     cond;
  } dec_pkt_t;

  // Add/sub mnemonic from the {op, S} bit pair shared by imm and reg forms.
  function automatic opcode_t arith_opcode(input logic [1:0] op_s);
    case (op_s)
      2'b00:   arith_opcode = OP_ADD;
      2'b01:   arith_opcode = OP_ADDS;
      2'b10:   arith_opcode = OP_SUB;
      default: arith_opcode = OP_SUBS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dispatch_decode_decoder.sv
`default_nettype none
// ============================================================================
// Module      : a64_decoder
// Description : Combinational A64 integer-subset decoder producing one
//               dispatch packet and a recognised flag per instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
module a64_decoder
  import dispatch_decode_pkg::*;
(
  input  logic [31:0] i_insn,
  output logic        o_valid,
  output dec_pkt_t    o_pkt
);

  logic [GPR_IDX_SIZE-1:0] w_rd;
  logic [GPR_IDX_SIZE-1:0] w_rn;
  logic [GPR_IDX_SIZE-1:0] w_rm;
  logic [10:0]             w_op11;

  assign w_rd   = i_insn[4:0];
  assign w_rn   = i_insn[9:5];
  assign w_rm   = i_insn[20:16];
  assign w_op11 = i_insn[31:21];

  // Priority decode of the supported formats; anything else leaves o_valid low.
  always_comb begin
    o_valid       = 1'b0;
    o_pkt         = '0;
    o_pkt.opcode  = OP_ERROR;
    o_pkt.src1    = GPR_XZR;
    o_pkt.src2    = GPR_XZR;
    o_pkt.dst     = GPR_XZR;
    o_pkt.cond    = COND_AL;
    o_pkt.fu_id   = FU_ALU;
    o_pkt.fu_op   = FU_OP_PASS;

    if (i_insn == NOP_INSN) begin
      o_valid      = 1'b1;
      o_pkt.opcode = OP_NOP;
      o_pkt.fu_id  = FU_NONE;
    end else if (w_op11 == 11'b11010100010) begin
      o_valid      = 1'b1;
      o_pkt.opcode = OP_HLT;
      o_pkt.fu_id  = FU_NONE;
    end else if (i_insn[31:24] == 8'b01010100 && !i_insn[4]) begin
      // B.cond: word offset scaled to bytes, flags consumed.
      o_valid         = 1'b1;
      o_pkt.opcode    = OP_BCOND;
      o_pkt.fu_op     = FU_OP_BCOND;
      o_pkt.use_imm   = 1'b1;
      o_pkt.imm       = {{(IMMEDIATE_SIZE-21){i_insn[23]}}, i_insn[23:5], 2'b00};
      o_pkt.uses_nzcv = 1'b1;
      o_pkt.cond      = i_insn[3:0];
    end else if (i_insn[31:23] == 9'b110100101) begin
      // MOVZ: 16-bit chunk placed at one of four half-word lanes.
      o_valid       = 1'b1;
      o_pkt.opcode  = OP_MOVZ;
      o_pkt.fu_op   = FU_OP_MOV;
      o_pkt.dst     = w_rd;
      o_pkt.use_imm = 1'b1;
      o_pkt.imm     = IMMEDIATE_SIZE'(i_insn[20:5]) << {i_insn[22:21], 4'b0000};
    end else if (w_op11 == 11'b11111000010 || w_op11 == 11'b11111000000) begin
      // LDUR/STUR: the LS unit adds the signed offset to the base register.
      o_valid       = 1'b1;
      o_pkt.fu_id   = FU_LS;
      o_pkt.fu_op   = FU_OP_PLUS;
      o_pkt.src1    = w_rn;
      o_pkt.use_imm = 1'b1;
      o_pkt.imm     = {{(IMMEDIATE_SIZE-9){i_insn[20]}}, i_insn[20:12]};
      if (i_insn[22]) begin
        o_pkt.opcode = OP_LDUR;
        o_pkt.dst    = w_rd;
      end else begin
        o_pkt.opcode = OP_STUR;
        o_pkt.src2   = w_rd;
      end
    end else if (i_insn[31] && i_insn[28:22] == 7'b1000100) begin
      // ADD/ADDS/SUB/SUBS immediate; bit 30 selects subtract, bit 29 flags.
      o_valid        = 1'b1;
      o_pkt.opcode   = arith_opcode(i_insn[30:29]);
      o_pkt.fu_op    = i_insn[30] ? FU_OP_MINUS : FU_OP_PLUS;
      o_pkt.set_nzcv = i_insn[29];
      o_pkt.src1     = w_rn;
      o_pkt.dst      = w_rd;
      o_pkt.use_imm  = 1'b1;
      o_pkt.imm      = IMMEDIATE_SIZE'(i_insn[21:10]);
    end else if (i_insn[31] && i_insn[28:21] == 8'b01011000) begin
      // ADD/ADDS/SUB/SUBS register; the shift amount field is not honoured.
      o_valid        = 1'b1;
      o_pkt.opcode   = arith_opcode(i_insn[30:29]);
      o_pkt.fu_op    = i_insn[30] ? FU_OP_MINUS : FU_OP_PLUS;
      o_pkt.set_nzcv = i_insn[29];
      o_pkt.src1     = w_rn;
      o_pkt.src2     = w_rm;
      o_pkt.dst      = w_rd;
    end else begin
      case (w_op11)
        11'b10001010000: begin
          o_valid      = 1'b1;
          o_pkt.opcode = OP_AND;
          o_pkt.fu_op  = FU_OP_AND;
        end
        11'b10101010000: begin
          o_valid      = 1'b1;
          o_pkt.opcode = OP_ORR;
          o_pkt.fu_op  = FU_OP_ORR;
        end
        11'b11001010000: begin
          o_valid      = 1'b1;
          o_pkt.opcode = OP_EOR;
          o_pkt.fu_op  = FU_OP_EOR;
        end
        11'b11101010000: begin
          o_valid        = 1'b1;
          o_pkt.opcode   = OP_ANDS;
          o_pkt.fu_op    = FU_OP_AND;
          o_pkt.set_nzcv = 1'b1;
        end
        // MVN is ORN with Rn = XZR and needs no separate handling.
        11'b10101010001: begin
          o_valid      = 1'b1;
          o_pkt.opcode = OP_ORN;
          o_pkt.fu_op  = FU_OP_ORN;
        end
        11'b10011010100: begin
          if (i_insn[11:10] == 2'b00) begin
            o_valid      = 1'b1;
            o_pkt.opcode = OP_CSEL;
            o_pkt.fu_op  = FU_OP_CSEL;
          end else if (i_insn[11:10] == 2'b01) begin
            o_valid      = 1'b1;
            o_pkt.opcode = OP_CSINC;
            o_pkt.fu_op  = FU_OP_CSINC;
          end
          o_pkt.uses_nzcv = 1'b1;
          o_pkt.cond      = i_insn[15:12];
        end
        11'b11011010100: begin
          if (i_insn[11:10] == 2'b00) begin
            o_valid      = 1'b1;
            o_pkt.opcode = OP_CSINV;
            o_pkt.fu_op  = FU_OP_CSINV;
          end else if (i_insn[11:10] == 2'b01) begin
            o_valid      = 1'b1;
            o_pkt.opcode = OP_CSNEG;
            o_pkt.fu_op  = FU_OP_CSNEG;
          end
          o_pkt.uses_nzcv = 1'b1;
          o_pkt.cond      = i_insn[15:12];
        end
        default: ;
      endcase
      // All register-register logical and conditional-select forms share
      // the Rn/Rm/Rd operand layout.
      if (o_valid) begin
        o_pkt.src1 = w_rn;
        o_pkt.src2 = w_rm;
        o_pkt.dst  = w_rd;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dispatch_decode.sv
`default_nettype none
// ============================================================================
// Module      : dispatch_decode
// Description : Decode stage - registers one decoded dispatch packet per
//               consumed fetch word, with squash and back-pressure handling.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatch_decode
  import dispatch_decode_pkg::*;
(
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_stall,
  input  logic [31:0]               in_fetch_insnbits,
  input  logic                      in_fetch_done,
  input  logic                      in_reg_correction,
  output logic                      out_reg_done,
  output opcode_t                   out_reg_opcode,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_src1,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_src2,
  output logic [GPR_IDX_SIZE-1:0]   out_reg_dst,
  output logic                      out_reg_use_imm,
  output logic [IMMEDIATE_SIZE-1:0] out_reg_imm,
  output fu_t                       out_reg_fu_id,
  output fu_op_t                    out_reg_fu_op,
  output logic                      out_reg_set_nzcv,
  output logic                      out_reg_instr_uses_nzcv,
  output cond_t                     out_reg_cond_codes
);

  logic     w_dec_valid;
  dec_pkt_t w_dec_pkt;
  logic     w_consume;

  dec_pkt_t pkt_d;
  dec_pkt_t pkt_q;
  logic     done_d;
  logic     done_q;

  a64_decoder u_decoder (
    .i_insn  (in_fetch_insnbits),
    .o_valid (w_dec_valid),
    .o_pkt   (w_dec_pkt)
  );

  // Correction and stall both block capture; correction needs no separate
  // path since neither case loads the packet.
  assign w_consume = in_fetch_done && !in_stall && !in_reg_correction;

  // Next packet: load on a recognised word, flag OP_ERROR on an unrecognised
  // one, otherwise hold every field and drop the valid pulse.
  always_comb begin
    pkt_d  = pkt_q;
    done_d = 1'b0;
    if (w_consume) begin
      if (w_dec_valid) begin
        pkt_d  = w_dec_pkt;
        done_d = 1'b1;
      end else begin
        pkt_d.opcode = OP_ERROR;
      end
    end
  end

  // Output register with asynchronous active-low clear.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      pkt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      pkt_q  <= pkt_d;
      done_q <= done_d;
    end
  end

  assign out_reg_done            = done_q;
  assign out_reg_opcode          = pkt_q.opcode;
  assign out_reg_src1            = pkt_q.src1;
  assign out_reg_src2            = pkt_q.src2;
  assign out_reg_dst             = pkt_q.dst;
  assign out_reg_use_imm         = pkt_q.use_imm;
  assign out_reg_imm             = pkt_q.imm;
  assign out_reg_fu_id           = pkt_q.fu_id;
  assign out_reg_fu_op           = pkt_q.fu_op;
  assign out_reg_set_nzcv        = pkt_q.set_nzcv;
  assign out_reg_instr_uses_nzcv = pkt_q.uses_nzcv;
  assign out_reg_cond_codes      = pkt_q.cond;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatch_decode
// Description : Directed table-driven bench for the dispatch decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatch_decode;
  import dispatch_decode_pkg::*;

  logic        clk;
  logic        in_rst;
  logic        in_stall;
  logic [31:0] in_fetch_insnbits;
  logic        in_fetch_done;
  logic        in_reg_correction;
  logic        out_reg_done;
  opcode_t     out_reg_opcode;
  logic [4:0]  out_reg_src1;
  logic [4:0]  out_reg_src2;
  logic [4:0]  out_reg_dst;
  logic        out_reg_use_imm;
  logic [63:0] out_reg_imm;
  fu_t         out_reg_fu_id;
  fu_op_t      out_reg_fu_op;
  logic        out_reg_set_nzcv;
  logic        out_reg_instr_uses_nzcv;
  cond_t       out_reg_cond_codes;

  int checks;
  int errors;

  dispatch_decode dut (
    .in_clk                  (clk),
    .in_rst                  (in_rst),
    .in_stall                (in_stall),
    .in_fetch_insnbits       (in_fetch_insnbits),
    .in_fetch_done           (in_fetch_done),
    .in_reg_correction       (in_reg_correction),
    .out_reg_done            (out_reg_done),
    .out_reg_opcode          (out_reg_opcode),
    .out_reg_src1            (out_reg_src1),
    .out_reg_src2            (out_reg_src2),
    .out_reg_dst             (out_reg_dst),
    .out_reg_use_imm         (out_reg_use_imm),
    .out_reg_imm             (out_reg_imm),
    .out_reg_fu_id           (out_reg_fu_id),
    .out_reg_fu_op           (out_reg_fu_op),
    .out_reg_set_nzcv        (out_reg_set_nzcv),
    .out_reg_instr_uses_nzcv (out_reg_instr_uses_nzcv),
    .out_reg_cond_codes      (out_reg_cond_codes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] insn;
    logic        done;
    opcode_t     opcode;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dst;
    logic        use_imm;
    logic [63:0] imm;
    fu_t         fu;
    fu_op_t      fu_op;
    logic        set_nzcv;
    logic        uses_nzcv;
    logic [3:0]  cond;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [31:0] insn, input logic done, input opcode_t opc,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                              input logic ui, input logic [63:0] imm, input fu_t fu,
                              input fu_op_t op, input logic sn, input logic un,
                              input logic [3:0] cond);
    vec_t v;
    v.insn = insn; v.done = done; v.opcode = opc; v.src1 = s1; v.src2 = s2; v.dst = d;
    v.use_imm = ui; v.imm = imm; v.fu = fu; v.fu_op = op; v.set_nzcv = sn;
    v.uses_nzcv = un; v.cond = cond;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".done"},   64'(out_reg_done),            64'(v.done));
    chk({tag, ".opcode"}, 64'(out_reg_opcode),          64'(v.opcode));
    chk({tag, ".src1"},   64'(out_reg_src1),            64'(v.src1));
    chk({tag, ".src2"},   64'(out_reg_src2),            64'(v.src2));
    chk({tag, ".dst"},    64'(out_reg_dst),             64'(v.dst));
    chk({tag, ".useimm"}, 64'(out_reg_use_imm),         64'(v.use_imm));
    chk({tag, ".imm"},    out_reg_imm,                  v.imm);
    chk({tag, ".fu_id"},  64'(out_reg_fu_id),           64'(v.fu));
    chk({tag, ".fu_op"},  64'(out_reg_fu_op),           64'(v.fu_op));
    chk({tag, ".setnz"},  64'(out_reg_set_nzcv),        64'(v.set_nzcv));
    chk({tag, ".usenz"},  64'(out_reg_instr_uses_nzcv), 64'(v.uses_nzcv));
    chk({tag, ".cond"},   64'(out_reg_cond_codes),      64'(v.cond));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".done"},   64'(out_reg_done),   64'd0);
    chk({tag, ".opcode"}, 64'(out_reg_opcode), 64'd0);
    chk({tag, ".src1"},   64'(out_reg_src1),   64'd0);
    chk({tag, ".dst"},    64'(out_reg_dst),    64'd0);
    chk({tag, ".imm"},    out_reg_imm,         64'd0);
    chk({tag, ".fu_id"},  64'(out_reg_fu_id),  64'd0);
    chk({tag, ".fu_op"},  64'(out_reg_fu_op),  64'd0);
    chk({tag, ".cond"},   64'(out_reg_cond_codes), 64'd0);
  endtask

  // Present inputs at the falling edge, then sample just after the next rise.
  task automatic drive(input logic [31:0] insn, input logic fd, input logic st, input logic corr);
    @(negedge clk);
    in_fetch_insnbits = insn;
    in_fetch_done     = fd;
    in_stall          = st;
    in_reg_correction = corr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    in_rst            = 1'b0;
    in_stall          = 1'b0;
    in_fetch_insnbits = 32'h0;
    in_fetch_done     = 1'b0;
    in_reg_correction = 1'b0;

    //        insn          done opcode    s1  s2  d  ui imm                    fu       fu_op        sn un cond
    vecs[0]  = mk(32'hB1001441, 1, OP_ADDS,  2, 31,  1, 1, 64'd5,                FU_ALU,  FU_OP_PLUS,  1, 0, 4'hE);
    vecs[1]  = mk(32'hCB050083, 1, OP_SUB,   4,  5,  3, 0, 64'd0,                FU_ALU,  FU_OP_MINUS, 0, 0, 4'hE);
    vecs[2]  = mk(32'hF85F8107, 1, OP_LDUR,  8, 31,  7, 1, 64'hFFFFFFFFFFFFFFF8, FU_LS,   FU_OP_PLUS,  0, 0, 4'hE);
    vecs[3]  = mk(32'h54000041, 1, OP_BCOND,31, 31, 31, 1, 64'd8,                FU_ALU,  FU_OP_BCOND, 0, 1, 4'h1);
    vecs[4]  = mk(32'hF8010041, 1, OP_STUR,  2,  1, 31, 1, 64'd16,               FU_LS,   FU_OP_PLUS,  0, 0, 4'hE);
    vecs[5]  = mk(32'hD2A24689, 1, OP_MOVZ, 31, 31,  9, 1, 64'h12340000,         FU_ALU,  FU_OP_MOV,   0, 0, 4'hE);
    vecs[6]  = mk(32'hAA2C016A, 1, OP_ORN,  11, 12, 10, 0, 64'd0,                FU_ALU,  FU_OP_ORN,   0, 0, 4'hE);
    vecs[7]  = mk(32'hEA030041, 1, OP_ANDS,  2,  3,  1, 0, 64'd0,                FU_ALU,  FU_OP_AND,   1, 0, 4'hE);
    vecs[8]  = mk(32'h9A830441, 1, OP_CSINC, 2,  3,  1, 0, 64'd0,                FU_ALU,  FU_OP_CSINC, 0, 1, 4'h0);
    vecs[9]  = mk(32'hDA86C4A4, 1, OP_CSNEG, 5,  6,  4, 0, 64'd0,                FU_ALU,  FU_OP_CSNEG, 0, 1, 4'hC);
    vecs[10] = mk(32'hD503201F, 1, OP_NOP,  31, 31, 31, 0, 64'd0,                FU_NONE, FU_OP_PASS,  0, 0, 4'hE);
    vecs[11] = mk(32'hD4400000, 1, OP_HLT,  31, 31, 31, 0, 64'd0,                FU_NONE, FU_OP_PASS,  0, 0, 4'hE);
    // Unrecognised word after HLT: only opcode changes, the rest holds.
    vecs[12] = mk(32'h00000000, 0, OP_ERROR,31, 31, 31, 0, 64'd0,                FU_NONE, FU_OP_PASS,  0, 0, 4'hE);

    // Reset held, then released with nothing fetched.
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    in_rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_rel");

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].insn, 1'b1, 1'b0, 1'b0);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall: the next word is not consumed, fields hold the previous packet.
    drive(32'hCB050083, 1'b1, 1'b0, 1'b0);
    check_vec("pre_stall", vecs[1]);
    drive(32'hB1001441, 1'b1, 1'b1, 1'b0);
    chk("stall.done",   64'(out_reg_done),    64'd0);
    chk("stall.opcode", 64'(out_reg_opcode),  64'(OP_SUB));
    chk("stall.src1",   64'(out_reg_src1),    64'd4);
    chk("stall.useimm", 64'(out_reg_use_imm), 64'd0);

    // Correction wins over stall and fetch_done, with and without stall.
    drive(32'hB1001441, 1'b1, 1'b1, 1'b1);
    chk("corr_st.done",   64'(out_reg_done),   64'd0);
    chk("corr_st.opcode", 64'(out_reg_opcode), 64'(OP_SUB));
    drive(32'hB1001441, 1'b1, 1'b0, 1'b1);
    chk("corr.done",   64'(out_reg_done),   64'd0);
    chk("corr.src1",   64'(out_reg_src1),   64'd4);
    chk("corr.opcode", 64'(out_reg_opcode), 64'(OP_SUB));

    // Back-to-back valid words, then fetch_done low.
    drive(32'hB1001441, 1'b1, 1'b0, 1'b0);
    check_vec("b2b0", vecs[0]);
    drive(32'hF85F8107, 1'b1, 1'b0, 1'b0);
    check_vec("b2b1", vecs[2]);
    drive(32'hB1001441, 1'b0, 1'b0, 1'b0);
    chk("idle.done", 64'(out_reg_done), 64'd0);
    chk("idle.dst",  64'(out_reg_dst),  64'd7);

    // Asynchronous reset with a valid packet on the outputs, no clock edge.
    drive(32'hB1001441, 1'b1, 1'b0, 1'b0);
    chk("arst_pre.done", 64'(out_reg_done), 64'd1);
    #2;
    in_rst = 1'b0;
    #1;
    check_zero("arst");
    @(negedge clk);
    in_rst = 1'b1;
    drive(32'h00000000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatch_decode.md
Name: dispatch_decode

Overview:
- Decode stage of the Tomasulo core.
- Accepts one 32-bit A64 instruction word per cycle from fetch and decodes a fixed integer subset.
- Drives one registered dispatch packet to the register file: source/destination GPR indices, immediate, functional-unit id and op, NZCV production/consumption, and condition code.
- Squashes on branch correction and holds under back-pressure.

Parameters:
- GPR_IDX_SIZE, 5, GPR index width; index 31 = XZR/unused.
- IMMEDIATE_SIZE, 64, immediate width.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst  input  1  reset, asynchronous, active-low.
- in_stall  input  1  downstream full; do not consume.
- in_fetch_insnbits  input  32  instruction word.
- in_fetch_done  input  1  in_fetch_insnbits is valid this cycle.
- in_reg_correction  input  1  mispredict squash.
- out_reg_done  output  1  packet valid, one pulse per instruction.
- out_reg_opcode  output  opcode_t  decoded mnemonic.
- out_reg_src1  output  GPR_IDX_SIZE  first source.
- out_reg_src2  output  GPR_IDX_SIZE  second source.
- out_reg_dst  output  GPR_IDX_SIZE  destination; 31 = no write.
- out_reg_use_imm  output  1  immediate replaces src2 operand.
- out_reg_imm  output  IMMEDIATE_SIZE  extended immediate.
- out_reg_fu_id  output  fu_t  target unit.
- out_reg_fu_op  output  fu_op_t  unit operation.
- out_reg_set_nzcv  output  1  instruction writes flags.
- out_reg_instr_uses_nzcv  output  1  instruction reads flags.
- out_reg_cond_codes  output  cond_t  condition field.

Behaviour:
- Reset (in_rst=0, async): all outputs are 0. Enums take their 0 encoding (OP_NOP, FU_NONE, FU_OP_PASS).
- All outputs are registered. Latency is 1 cycle.
  - A word is consumed at a rising edge when in_fetch_done=1, in_stall=0 and in_reg_correction=0.
  - out_reg_done=1 in the following cycle iff the word decodes; otherwise out_reg_done=0.
- in_stall=1: out_reg_done drops to 0 next cycle; other outputs hold their values.
- in_reg_correction=1: no capture; out_reg_done=0 next cycle. Correction has priority over stall and fetch_done.
- Unrecognised word (including 0x00000000): out_reg_done=0, opcode=OP_ERROR, other fields hold.
- Defaults for every decoded packet: src1=src2=dst=31, use_imm=0, imm=0, set_nzcv=0, uses_nzcv=0, cond=4'b1110 (AL).
- Decode table (Rd=[4:0], Rn=[9:5], Rm=[20:16]):
  - ADD/ADDS/SUB/SUBS imm, [31:22]=1001000100/1011000100/1101000100/1111000100:
    - src1=Rn, dst=Rd, use_imm=1, imm=zext(imm12[21:10]).
    - fu_op PLUS/MINUS; S forms set_nzcv=1.
  - ADD/ADDS/SUB/SUBS reg, [31:21]=10001011000/10101011000/11001011000/11101011000:
    - src1=Rn, src2=Rm, dst=Rd; shift amount is ignored.
  - AND/ORR/EOR/ANDS/ORN reg, [31:21]=10001010000/10101010000/11001010000/11101010000/10101010001:
    - fu_op AND/ORR/EOR/AND/ORN; ANDS sets nzcv. MVN decodes as ORN with Rn=31.
  - MOVZ, [31:23]=110100101: src1=31, dst=Rd, use_imm=1, imm=zext(imm16[20:5])<<(16*hw[22:21]), fu_op MOV.
  - LDUR, [31:21]=11111000010: fu_id FU_LS, src1=Rn, dst=Rt, use_imm=1, imm=sext(imm9[20:12]).
  - STUR, [31:21]=11111000000: fu_id FU_LS, src1=Rn, src2=Rt, dst=31, use_imm=1, imm=sext(imm9[20:12]).
  - B.cond, [31:24]=01010100 and [4]=0: use_imm=1, imm=sext(imm19[23:5])<<2, uses_nzcv=1, cond=[3:0], fu_op BCOND.
  - CSEL/CSINC/CSINV/CSNEG, [31:21]=10011010100 (op [11:10]=00/01) or 11011010100 (00/01):
    - src1=Rn, src2=Rm, dst=Rd, cond=[15:12], uses_nzcv=1.
  - NOP (0xD503201F) and HLT ([31:21]=11010100010): done=1, fu_id FU_NONE, fu_op PASS.
- All ALU-class instructions above use fu_id FU_ALU unless stated otherwise.

Decomposition:
- Shared package holds:
  - constants GPR_IDX_SIZE, GPR_SIZE=64, IMMEDIATE_SIZE, ROB_IDX_SIZE;
  - enums opcode_t, fu_t {FU_NONE, FU_ALU, FU_LS}, fu_op_t;
  - cond_t (4-bit) and nzcv_t.
- One combinational sub-module, a64_decoder (insnbits → packet fields), feeds the output register in dispatch_decode.

Test Plan:
- Reset: hold in_rst=0, then release → all outputs 0. Assert in_rst=0 mid-stream with out_reg_done=1 → out_reg_done clears immediately (no clock).
- 0xB1001441 (ADDS X1,X2,#5) with fetch_done=1 → next cycle: done=1, src1=2, dst=1, use_imm=1, imm=5, fu_op=PLUS, set_nzcv=1.
- 0xCB050083 (SUB X3,X4,X5) → src1=4, src2=5, dst=3, use_imm=0, fu_op=MINUS, set_nzcv=0.
- 0xF85F8107 (LDUR X7,[X8,#-8]) → fu_id=FU_LS, src1=8, dst=7, imm=0xFFFFFFFFFFFFFFF8.
- 0x54000041 (B.NE +8) → imm=8, uses_nzcv=1, cond=0001, dst=31.
- Back-to-back valid words:
  - in_stall=1 → done=0 next cycle with fields held;
  - in_reg_correction=1 → done=0;
  - 0x00000000 → done=0, opcode=OP_ERROR.
